// File: rtl/serial_subtractor_if.sv
// Handshake bundle for the bit-serial subtractor.
//   slave  : the subtractor side (accepts operands, produces the result)
//   master : the producer/consumer side (drives operands and out_ready)
// Signals
//   in_valid/in_ready/a_in/b_in      operand handshake
//   out_valid/out_ready/diff/borrow_out  result handshake
//   busy                             high while bits are being shifted
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             busy;

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, diff, borrow_out, busy
    );

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, diff, borrow_out, busy
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a_in - b_in (mod 2^WIDTH), LSB first,
// one bit per clock through a single full-subtractor cell and a borrow flop.
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : serial_subtractor_if.slave (operand/result handshakes, busy)
// Operands are captured on the accepting edge; the result is presented WIDTH
// cycles later and held until the consumer takes it. All outputs come straight
// from flops or decoded state, so no input reaches an output combinationally.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int              CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bf_q, bf_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             d_bit;
    logic [WIDTH-1:0] sr_next;

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        sr_d     = sr_q;
        diff_d   = diff_q;
        bf_d     = bf_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;

        // Full-subtractor cell on the current LSBs
        d_bit   = sa_q[0] ^ sb_q[0] ^ bf_q;
        sr_next = {d_bit, sr_q[WIDTH-1:1]};

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sa_d    = bus.a_in;
                    sb_d    = bus.b_in;
                    sr_d    = '0;
                    bf_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                bf_d  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bf_q);
                sr_d  = sr_next;
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // Last bit: publish the completed word and the final borrow
                    diff_d   = sr_next;
                    borrow_d = bf_d;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            sr_q     <= '0;
            diff_q   <= '0;
            bf_q     <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            sr_q     <= sr_d;
            diff_q   <= diff_d;
            bf_q     <= bf_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.busy       = (state_q == RUN);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
endmodule
